line_operand_unpacker: RTL and testbench

Upstream feeder for the clk_div2-domain arithmetic unit (multiplier/divider) in the division test AFU. Accepts one 512-bit read-response cache line at a time, holds up to two lines (active + pending), and issues the packed 32-bit operand pairs one per handshake to the arithmetic unit. It replaces the single-pair read_buffer hand-off and allows back-to-back lines with no bubble.

---
 rtl/line_operand_unpacker.sv | 169 ++++++++++++++++
 tb/tb_line_operand_unpacker.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_operand_unpacker.sv
// ---------------------------------------------------------------------------
// line_operand_unpacker
//
// Purpose:
//   Feeds the clk_div2-domain arithmetic unit (multiplier/divider) of the
//   division test AFU. Takes 512-bit read-response cache lines, keeps up to
//   two of them (an active line being issued and a pending line waiting),
//   and hands out the packed 32-bit operand pairs one per op handshake.
//   Holding a pending line lets the next line start on the cycle right after
//   the last pair of the current one, so back-to-back lines have no bubble.
//
// Ports:
//   i_clk          sole clock, all logic on posedge
//   i_rst_n        asynchronous active-low reset
//   i_flush        synchronous clear of both line buffers
//   i_line_valid   input line present
//   o_line_ready   a line can be taken this cycle (pending buffer empty)
//   i_line_data    line; pair i: a = [2*i*DATA_LEN +: DATA_LEN],
//                  b = [(2*i+1)*DATA_LEN +: DATA_LEN]
//   i_line_count   number of valid pairs minus one
//   o_op_valid     operand pair present
//   i_op_ready     arithmetic unit takes the pair
//   o_op_a/o_op_b  current operands
//   o_op_idx       index of current pair within its line
//   o_op_last      current pair is the last of its line
//   o_done         one-cycle pulse per completed line
//   o_busy         active or pending buffer occupied
//   o_line_cnt     completed lines, wraps 0xFFFF -> 0
// ---------------------------------------------------------------------------
module line_operand_unpacker #(
  parameter  int DATA_LEN  = 32,
  parameter  int LINE_BITS = 512,
  localparam int PAIRS     = LINE_BITS / (2 * DATA_LEN),
  localparam int CW        = $clog2(PAIRS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_line_valid,
  output logic                 o_line_ready,
  input  logic [LINE_BITS-1:0] i_line_data,
  input  logic [CW-1:0]        i_line_count,
  output logic                 o_op_valid,
  input  logic                 i_op_ready,
  output logic [DATA_LEN-1:0]  o_op_a,
  output logic [DATA_LEN-1:0]  o_op_b,
  output logic [CW-1:0]        o_op_idx,
  output logic                 o_op_last,
  output logic                 o_done,
  output logic                 o_busy,
  output logic [15:0]          o_line_cnt
);

  localparam int OFFW = $clog2(LINE_BITS);

  // The active side is either idle or issuing pairs of its line.
  typedef enum logic {
    EMPTY = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t               r_state;
  logic [LINE_BITS-1:0] r_act_data;
  logic [CW-1:0]        r_act_count;
  logic [CW-1:0]        r_act_idx;
  logic [LINE_BITS-1:0] r_pend_data;
  logic [CW-1:0]        r_pend_count;
  logic                 r_pend_valid;
  logic                 r_done;
  logic [15:0]          r_line_cnt;

  logic                 w_act_valid;
  logic                 w_accept;
  logic                 w_fire;
  logic                 w_last_fire;
  logic [OFFW-1:0]      w_a_off;
  logic [OFFW-1:0]      w_b_off;

  assign w_act_valid = (r_state == ISSUE);

  // Ready depends only on the pending register, never on i_line_valid.
  assign o_line_ready = !r_pend_valid;
  assign w_accept     = i_line_valid && o_line_ready;

  assign o_op_valid   = w_act_valid;
  assign o_op_idx     = r_act_idx;
  assign o_op_last    = w_act_valid && (r_act_idx == r_act_count);
  assign w_fire       = o_op_valid && i_op_ready;
  assign w_last_fire  = w_fire && o_op_last;

  // Each pair occupies 2*DATA_LEN bits; b sits DATA_LEN above a.
  assign w_a_off = OFFW'(r_act_idx) * OFFW'(2 * DATA_LEN);
  assign w_b_off = w_a_off + OFFW'(DATA_LEN);
  assign o_op_a  = r_act_data[w_a_off +: DATA_LEN];
  assign o_op_b  = r_act_data[w_b_off +: DATA_LEN];

  assign o_done     = r_done;
  assign o_busy     = w_act_valid || r_pend_valid;
  assign o_line_cnt = r_line_cnt;

  // Single sequential block for the active/pending buffers and counters.
  // A last-pair handshake always counts as a completed line, even in a
  // flush cycle; flush then wins over any accept or promotion. Since an
  // accept needs the pending slot empty, a promotion never coincides with
  // a new line entering pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= EMPTY;
      r_act_data   <= '0;
      r_act_count  <= '0;
      r_act_idx    <= '0;
      r_pend_data  <= '0;
      r_pend_count <= '0;
      r_pend_valid <= 1'b0;
      r_done       <= 1'b0;
      r_line_cnt   <= '0;
    end else begin
      r_done <= w_last_fire;
      if (w_last_fire) begin
        r_line_cnt <= r_line_cnt + 16'd1;
      end

      if (i_flush) begin
        r_state      <= EMPTY;
        r_pend_valid <= 1'b0;
        r_act_idx    <= '0;
      end else begin
        case (r_state)
          EMPTY: begin
            if (w_accept) begin
              r_state     <= ISSUE;
              r_act_data  <= i_line_data;
              r_act_count <= i_line_count;
              r_act_idx   <= '0;
            end
          end
          ISSUE: begin
            if (w_last_fire) begin
              if (r_pend_valid) begin
                r_act_data   <= r_pend_data;
                r_act_count  <= r_pend_count;
                r_act_idx    <= '0;
                r_pend_valid <= 1'b0;
              end else if (w_accept) begin
                r_act_data  <= i_line_data;
                r_act_count <= i_line_count;
                r_act_idx   <= '0;
              end else begin
                r_state   <= EMPTY;
                r_act_idx <= '0;
              end
            end else begin
              if (w_fire) begin
                r_act_idx <= r_act_idx + CW'(1);
              end
              if (w_accept) begin
                r_pend_data  <= i_line_data;
                r_pend_count <= i_line_count;
                r_pend_valid <= 1'b1;
              end
            end
          end
          default: r_state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_operand_unpacker.sv
// ---------------------------------------------------------------------------
// tb_line_operand_unpacker
//
// Purpose:
//   Self-checking bench for line_operand_unpacker. The stimulus side offers
//   lines of operand pairs and, when a line is taken, pushes the pairs it
//   expects to see into a scoreboard queue. A separate monitor, running on
//   the falling edge, compares the presented pair against the queue head and
//   tracks a simple occupancy model (lines held, lines completed) to predict
//   op_valid, busy, line_ready, done and line_cnt.
// ---------------------------------------------------------------------------
module tb_line_operand_unpacker;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  idx;
    logic        last;
  } pair_t;

  logic         clk = 1'b0;
  logic         rstN;
  logic         flush;
  logic         lineValid;
  logic         lineReady;
  logic [511:0] lineData;
  logic [2:0]   lineCount;
  logic         opValid;
  logic         opReady;
  logic [31:0]  opA;
  logic [31:0]  opB;
  logic [2:0]   opIdx;
  logic         opLast;
  logic         done;
  logic         busy;
  logic [15:0]  lineCnt;

  int           checks    = 0;
  int           errors    = 0;
  int           readyPct  = 100;
  int           held      = 0;
  logic [15:0]  modelLines = '0;
  logic         expDone   = 1'b0;
  pair_t        expQ[$];

  line_operand_unpacker dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_flush      (flush),
    .i_line_valid (lineValid),
    .o_line_ready (lineReady),
    .i_line_data  (lineData),
    .i_line_count (lineCount),
    .o_op_valid   (opValid),
    .i_op_ready   (opReady),
    .o_op_a       (opA),
    .o_op_b       (opB),
    .o_op_idx     (opIdx),
    .o_op_last    (opLast),
    .o_done       (done),
    .o_busy       (busy),
    .o_line_cnt   (lineCnt)
  );

  always #5 clk = ~clk;

  // Compare one value and keep the running tallies.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Random backpressure from the arithmetic unit.
  always @(posedge clk) begin
    #1;
    if (readyPct >= 100) opReady = 1'b1;
    else opReady = ($urandom_range(0, 99) < readyPct);
  end

  // Offer one line and push its pairs into the scoreboard once it is taken.
  // Entered and left at 1 time unit after a rising edge.
  task automatic applyStimulus(input int cnt, input bit seqData);
    logic [511:0] d;
    logic [31:0]  av[8];
    logic [31:0]  bv[8];
    bit           accepted;
    pair_t        p;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      if (seqData) begin
        av[i] = 32'(2 * i + 1);
        bv[i] = 32'(2 * i + 2);
      end else begin
        av[i] = $urandom;
        bv[i] = $urandom;
      end
      d[64*i +: 32]      = av[i];
      d[64*i + 32 +: 32] = bv[i];
    end
    lineValid = 1'b1;
    lineData  = d;
    lineCount = 3'(cnt);
    accepted  = 1'b0;
    for (int w = 0; w < 400 && !accepted; w++) begin
      @(negedge clk);
      if (lineReady && !flush) begin
        accepted = 1'b1;
        for (int i = 0; i <= cnt; i++) begin
          p.a    = av[i];
          p.b    = bv[i];
          p.idx  = 3'(i);
          p.last = (i == cnt);
          expQ.push_back(p);
        end
      end
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    lineValid = 1'b0;
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  // Wait for the unpacker to drain, plus one cycle for the final done.
  task automatic waitIdle();
    int w;
    w = 0;
    while (busy && w < 5000) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (busy) checkOutput("idle_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_op_valid", 32'(opValid), 32'd0);
    checkOutput("rst_op_a", opA, 32'd0);
    checkOutput("rst_op_b", opB, 32'd0);
    checkOutput("rst_op_idx", 32'(opIdx), 32'd0);
    checkOutput("rst_op_last", 32'(opLast), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_line_cnt", 32'(lineCnt), 32'd0);
    checkOutput("rst_line_ready", 32'(lineReady), 32'd1);
  endtask

  // Monitor: compares the presented state with the model, then advances the
  // model by what happens at the coming rising edge. Inputs only change just
  // after a rising edge, so values seen here are those the edge will use.
  always @(negedge clk) begin
    bit fire;
    bit lastFire;
    bit acc;
    #1;
    if (rstN) begin
      checkOutput("done", 32'(done), 32'(expDone));
      checkOutput("line_cnt", 32'(lineCnt), 32'(modelLines));
      checkOutput("op_valid", 32'(opValid), 32'(held > 0));
      checkOutput("busy", 32'(busy), 32'(held > 0));
      checkOutput("line_ready", 32'(lineReady), 32'(held < 2));
      if (held > 0) begin
        if (expQ.size() == 0) begin
          checkOutput("scoreboard_empty", 32'd0, 32'd1);
        end else begin
          checkOutput("op_a", opA, expQ[0].a);
          checkOutput("op_b", opB, expQ[0].b);
          checkOutput("op_idx", 32'(opIdx), 32'(expQ[0].idx));
          checkOutput("op_last", 32'(opLast), 32'(expQ[0].last));
        end
      end
      fire     = (held > 0) && opReady;
      lastFire = fire && (expQ.size() > 0) && expQ[0].last;
      acc      = lineValid && (held < 2) && !flush;
      expDone  = lastFire;
      if (lastFire) modelLines = modelLines + 16'd1;
      if (fire && expQ.size() > 0) void'(expQ.pop_front());
      if (lastFire) held--;
      if (acc) held++;
      if (flush) begin
        expQ.delete();
        held = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN      = 1'b1;
    flush     = 1'b0;
    lineValid = 1'b0;
    lineData  = '0;
    lineCount = '0;
    opReady   = 1'b0;
    #1 rstN = 1'b0;
    #11;
    checkResetValues();
    @(posedge clk);
    #2 rstN = 1'b1;
    @(posedge clk);
    #1;

    // Single sequential line of eight pairs, full throughput.
    readyPct = 100;
    applyStimulus(7, 1'b1);
    waitIdle();

    // Two short lines back to back.
    applyStimulus(1, 1'b0);
    applyStimulus(1, 1'b0);
    waitIdle();

    // Backpressure on a three-pair line.
    readyPct = 50;
    applyStimulus(2, 1'b0);
    waitIdle();

    // Third line offered while active and pending are both full.
    readyPct = 20;
    applyStimulus(7, 1'b0);
    applyStimulus(7, 1'b0);
    applyStimulus(7, 1'b0);
    waitIdle();

    // Flush mid-line with a pending line.
    readyPct = 60;
    applyStimulus(7, 1'b0);
    applyStimulus(3, 1'b0);
    pulseFlush();
    waitIdle();

    // Flush coincident with a last-pair handshake still completes the line.
    readyPct = 100;
    applyStimulus(0, 1'b0);
    pulseFlush();
    waitIdle();

    // Reset while pair 3 is being issued.
    applyStimulus(7, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("pre_reset_idx", 32'(opIdx), 32'd3);
    rstN = 1'b0;
    #1;
    checkResetValues();
    expQ.delete();
    held       = 0;
    modelLines = '0;
    expDone    = 1'b0;
    @(posedge clk);
    #2 rstN = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b0);
    waitIdle();

    // Randomized traffic with occasional flushes.
    for (int n = 0; n < 80; n++) begin
      readyPct = $urandom_range(30, 100);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      applyStimulus($urandom_range(0, 7), 1'b0);
      if ($urandom_range(0, 14) == 0) pulseFlush();
    end
    waitIdle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
